move_replay_buffer: RTL

- Downstream consumer of the rat-in-maze solver: captures the move strobes the solver emits and stores the path.
- Once the solver reports done, replays the stored path to a display/actuator stage over a valid/ready handshake.
- Reports path length, overflow and solver failure, so the next stage never sees a partial or failed path.

---
 rtl/maze_pkg.sv | 23 ++
 rtl/move_mem.sv | 23 ++
 rtl/move_replay_buffer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/maze_pkg.sv
// Shared maze types: move direction encoding (common with the solver),
// replay buffer state encoding and default sizing constants.
package maze_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_DOWN  = 2'b11
  } dir_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CAPTURE = 3'd1,
    ST_REPLAY  = 3'd2,
    ST_FINISH  = 3'd3,
    ST_ERR     = 3'd4
  } rpl_state_t;

  localparam int DEFAULT_DEPTH    = 256;
  localparam int DEFAULT_MAZE_DIM = 16;

endpackage

// File: rtl/move_mem.sv
// Move storage: DEPTH x 2-bit register array, synchronous write,
// asynchronous read, no reset (contents are don't-care until written).
module move_mem #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [1:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [1:0]    rdata
);

  logic [1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/move_replay_buffer.sv
// Captures solver moves, then replays the stored path over valid/ready.
// Optional position tracking is enabled with the MOVE_POS_TRACK_EN macro.
//
// state      | meaning
// IDLE       | waiting for start, solver inputs ignored
// CAPTURE    | storing move strobes until solver reports done/fail
// REPLAY     | presenting stored moves to the consumer
// FINISH     | path fully delivered (or empty), path_len holds count
// ERR        | overflow or solver failure, flags held until start
module move_replay_buffer
  import maze_pkg::*;
#(
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int MAZE_DIM = DEFAULT_MAZE_DIM,
  parameter int COORD_W  = 4,
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  input  logic [1:0]    in_dir,
  input  logic          solver_done,
  input  logic          solver_fail,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [1:0]    out_dir,
  output logic          out_last,
  output logic [CW-1:0] path_len,
  output logic          busy,
  output logic          overflow,
`ifdef MOVE_POS_TRACK_EN
  output logic [COORD_W-1:0] pos_row,
  output logic [COORD_W-1:0] pos_col,
  output logic               pos_err,
`endif
  output logic          fail
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (2 ** COORD_W) < MAZE_DIM) begin : g_bad_param
    $error("move_replay_buffer: DEPTH must be >= 2 and 2**COORD_W >= MAZE_DIM");
  end

  rpl_state_t    state, state_nxt;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_sum;
  logic          arm, take_move, drop_move, xfer, enter_replay;
  logic [1:0]    rd_data;

  assign take_move = (state == ST_CAPTURE) && in_valid && (count != CW'(DEPTH));
  assign drop_move = (state == ST_CAPTURE) && in_valid && (count == CW'(DEPTH));
  assign count_sum = count + CW'(take_move);

  assign out_valid = (state == ST_REPLAY);
  assign out_dir   = out_valid ? rd_data : 2'b00;
  assign out_last  = out_valid && (CW'(rd_ptr) == count - CW'(1));
  assign xfer      = out_valid && out_ready;
  assign busy      = (state == ST_CAPTURE) || (state == ST_REPLAY);
  assign path_len  = count;

  always_comb begin
    state_nxt = state;
    arm       = 1'b0;
    case (state)
      ST_IDLE, ST_FINISH, ST_ERR: begin
        if (start) begin
          state_nxt = ST_CAPTURE;
          arm       = 1'b1;
        end
      end
      ST_CAPTURE: begin
        // failure wins over done; a same-cycle move counts towards the path
        if (solver_fail || drop_move) state_nxt = ST_ERR;
        else if (solver_done)         state_nxt = (count_sum != '0) ? ST_REPLAY : ST_FINISH;
      end
      ST_REPLAY: begin
        if (xfer && out_last) state_nxt = ST_FINISH;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign enter_replay = (state == ST_CAPTURE) && (state_nxt == ST_REPLAY);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      fail     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (arm) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        overflow <= 1'b0;
        fail     <= 1'b0;
      end else begin
        if (take_move) begin
          count <= count_sum;
          // wr_ptr parks on the last slot so it never wraps past DEPTH-1
          if (wr_ptr != AW'(DEPTH - 1)) wr_ptr <= wr_ptr + AW'(1);
        end
        if (drop_move) overflow <= 1'b1;
        if ((state == ST_CAPTURE) && solver_fail) fail <= 1'b1;
        if (xfer && !out_last) rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  move_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (take_move),
    .waddr (wr_ptr),
    .wdata (in_dir),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

`ifdef MOVE_POS_TRACK_EN
  localparam logic [COORD_W-1:0] MAX_C = COORD_W'(MAZE_DIM - 1);

  always_ff @(posedge clk) begin
    if (!rst || arm || enter_replay) begin
      pos_row <= '0;
      pos_col <= '0;
      pos_err <= 1'b0;
    end else if (xfer) begin
      case (dir_t'(rd_data))
        DIR_UP: begin
          if (pos_row == '0) pos_err <= 1'b1;
          else               pos_row <= pos_row - COORD_W'(1);
        end
        DIR_DOWN: begin
          if (pos_row == MAX_C) pos_err <= 1'b1;
          else                  pos_row <= pos_row + COORD_W'(1);
        end
        DIR_LEFT: begin
          if (pos_col == '0) pos_err <= 1'b1;
          else               pos_col <= pos_col - COORD_W'(1);
        end
        default: begin
          if (pos_col == MAX_C) pos_err <= 1'b1;
          else                  pos_col <= pos_col + COORD_W'(1);
        end
      endcase
    end
  end
`endif

endmodule
